demo_responder: RTL and testbench

//  Responder end of the demo valid/ready request/response protocol driven by the demo

---
 rtl/demo_if.sv | 26 ++
 rtl/demo_responder.sv | 138 +++++++++++++
 tb/tb_demo_responder.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demo_if.sv
// Request/response bus between the demo agent (master) and demo_responder (slave).
// Both channels use valid/ready: a beat transfers on a rising clk edge where valid && ready are both high.
interface demo_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/demo_responder.sv
// Responder for the demo request/response bus: in-order request FIFO feeding an
// IDLE/WAIT/RESP engine that executes reads/writes on a register array after RSP_LAT cycles.
module demo_responder #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_DEPTH  = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int RSP_LAT    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  demo_if.slave                         bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic [1:0]                    state_dbg
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(RSP_LAT + 1);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic              w_write;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic              fifo_write [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wdata [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic in_range;

  // No bypass: a slot freed by this cycle's pop is only usable next cycle.
  assign full          = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign empty         = (fifo_cnt == '0);
  assign bus.req_ready = rst_n && !full;
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = (state == IDLE) && !empty;
  assign in_range      = ({1'b0, w_addr} < MEM_LIMIT);

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write[wr_ptr] <= bus.req_write;
      fifo_addr[wr_ptr]  <= bus.req_addr;
      fifo_wdata[wr_ptr] <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      w_write     <= 1'b0;
      w_addr      <= '0;
      w_wdata     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            w_write <= fifo_write[rd_ptr];
            w_addr  <= fifo_addr[rd_ptr];
            w_wdata <= fifo_wdata[rd_ptr];
            lat_cnt <= LAT_W'(RSP_LAT);
            state   <= WAIT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          // Access happens on the last WAIT cycle so the response is ready on entry to RESP.
          if (lat_cnt == LAT_W'(1)) begin
            if (!in_range) begin
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (w_write) begin
              mem[w_addr[IDX_W-1:0]] <= w_wdata;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= '0;
            end else begin
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= mem[w_addr[IDX_W-1:0]];
            end
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demo_responder.sv
// Randomized scoreboard bench for demo_responder: requests are scored against an
// in-order memory model at acceptance; a monitor pops and compares each response.
module tb_demo_responder;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int MEM_DEPTH  = 64;
  localparam int FIFO_DEPTH = 4;
  localparam int RSP_LAT    = 2;

  logic clk;
  logic rst_n;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  logic [1:0] state_dbg;

  demo_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  demo_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH),
    .FIFO_DEPTH(FIFO_DEPTH), .RSP_LAT(RSP_LAT)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fifo_cnt  (fifo_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int n_rsp  = 0;
  int acc_cyc = 0;
  int rsp_mode = 0;  // 0: rsp_ready high, 1: random, 2: low
  logic [DATA_W:0]   exp_q[$];   // {err, rdata}
  int                rise_q[$];
  logic [DATA_W-1:0] model_mem [MEM_DEPTH];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = '0;
    exp_q.delete();
    rise_q.delete();
  endtask

  // Reference behaviour: responses come back in acceptance order, so applying
  // each request to the model as it is accepted yields the exact response.
  task automatic model_accept(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (int'(a) >= MEM_DEPTH) exp_q.push_back({1'b1, {DATA_W{1'b0}}});
    else if (w) begin
      model_mem[a] = d;
      exp_q.push_back({1'b0, {DATA_W{1'b0}}});
    end else exp_q.push_back({1'b0, model_mem[a]});
  endtask

  // ---------------- rsp_ready driver ----------------
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rsp_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = 1'($urandom_range(0, 1));
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    logic              prev_v;
    logic              held_v;
    logic [DATA_W:0]   held;
    logic [DATA_W:0]   act;
    prev_v = 1'b0;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        held_v = 1'b0;
        continue;
      end
      act = {bus.rsp_err, bus.rsp_rdata};
      if (bus.rsp_valid && !prev_v) rise_q.push_back(cyc);
      if (held_v && bus.rsp_valid) chk("rsp_stable", 64'(act), 64'(held));
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rsp_unexpected: got 0x%0h with no request outstanding", act);
        end else chk("rsp", 64'(act), 64'(exp_q.pop_front()));
        held_v = 1'b0;
      end else if (bus.rsp_valid) begin
        held_v = 1'b1;
        held   = act;
      end else held_v = 1'b0;
      prev_v = bus.rsp_valid;
    end
  end

  // ---------------- request driver ----------------
  // Called and returns at posedge+1.
  task automatic send(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic acc;
    acc = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc = bus.req_ready && rst_n;
      if (acc) begin
        model_accept(w, a, d);
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("req_accept_timeout", 64'(acc), 64'(1));
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t0;
    int rsp0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst_n = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #2;
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("reset_req_ready", 64'(bus.req_ready), 64'(0));
    chk("reset_fifo_cnt",  64'(fifo_cnt), 64'(0));
    chk("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    chk("reset_rsp_err",   64'(bus.rsp_err), 64'(0));
    chk("reset_state",     64'(state_dbg), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_req_ready", 64'(bus.req_ready), 64'(1));

    // Write then read with latency and throughput check.
    rsp_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rise_q.delete();
    send(1'b1, 8'h10, 32'hDEADBEEF);
    t0 = acc_cyc;
    send(1'b0, 8'h10, 32'h0);
    drain();
    chk("rsp_count_latency", 64'(rise_q.size()), 64'(2));
    if (rise_q.size() == 2) begin
      chk("first_rsp_latency", 64'(rise_q[0] - t0), 64'(RSP_LAT + 2));
      chk("rsp_throughput", 64'(rise_q[1] - rise_q[0]), 64'(RSP_LAT + 2));
    end

    // Out of range plus last legal word.
    send(1'b1, 8'd64, 32'h1234);
    send(1'b0, 8'd64, 32'h0);
    send(1'b0, 8'd63, 32'h0);
    send(1'b0, 8'hFF, 32'h0);
    drain();

    // Reset mid-operation: memory cleared, queued work discarded.
    send(1'b1, 8'd5, 32'hA5A5_5A5A);
    drain();
    rsp_mode = 2;
    send(1'b0, 8'd5, 32'h0);
    send(1'b1, 8'd6, 32'h1111);
    send(1'b0, 8'd7, 32'h0);
    repeat (4) @(posedge clk);
    #3;
    chk("pre_reset_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("async_reset_req_ready", 64'(bus.req_ready), 64'(0));
    chk("async_reset_fifo_cnt",  64'(fifo_cnt), 64'(0));
    model_clear();
    rsp_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rsp0 = n_rsp;
    send(1'b0, 8'd5, 32'h0);
    send(1'b0, 8'd6, 32'h0);
    drain();
    chk("post_reset_rsp_count", 64'(n_rsp - rsp0), 64'(2));

    // Backpressure: 1 in RESP, 4 in FIFO, 6th waits for space.
    rsp_mode = 2;
    rsp0 = n_rsp;
    for (int i = 0; i < 5; i++) send(1'b1, 8'(32 + i), $urandom);
    fork
      send(1'b0, 8'd34, 32'h0);
      begin
        repeat (RSP_LAT + 2) @(negedge clk);
        chk("bp_fifo_cnt",  64'(fifo_cnt), 64'(FIFO_DEPTH));
        chk("bp_req_ready", 64'(bus.req_ready), 64'(0));
        chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        chk("bp_state",     64'(state_dbg), 64'(2));
        rsp_mode = 0;
      end
    join
    drain();
    chk("bp_rsp_count", 64'(n_rsp - rsp0), 64'(6));

    // Stability: hold a read response for 3 cycles, then accept it once.
    rsp_mode = 2;
    rsp0 = n_rsp;
    send(1'b0, 8'd33, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    chk("stall_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    repeat (3) @(negedge clk);
    rsp_mode = 0;
    drain();
    chk("stall_rsp_count", 64'(n_rsp - rsp0), 64'(1));

    // Wrap: sequential writes then reads with random backpressure.
    rsp_mode = 1;
    rsp0 = n_rsp;
    for (int i = 0; i < 20; i++) send(1'b1, 8'(i), $urandom);
    for (int i = 0; i < 20; i++) send(1'b0, 8'(i), 32'h0);
    drain();
    chk("wrap_rsp_count", 64'(n_rsp - rsp0), 64'(40));

    // Random mix including out-of-range addresses and read-after-write hazards.
    for (int i = 0; i < 60; i++)
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 70)), $urandom);
    drain();
    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
